// File: rtl/processor_gen2.sv
// Multicycle shared-bus processor: eight registers, IR, A and G on one bus, T0..T3 step FSM.
// Optional bitwise and/or opcodes are enabled with the PROC_LOGIC_OPS_EN macro.
module processor_gen2 #(
  parameter int unsigned DATA_W = 9
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic              Done,
  output logic [DATA_W-1:0] Bus
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_MVNZ = 3'b110,
    OP_RSVD = 3'b111
  } opcode_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] g_q;
  logic [DATA_W-1:0] r_q [8];

  opcode_t           op;
  logic [2:0]        rx_sel, ry_sel;
  logic              is_alu;
  logic [DATA_W-1:0] bus_c, alu_c;
  logic              done_c, ir_we, rx_we, a_we, g_we;

  assign op     = opcode_t'(ir_q[DATA_W-1 -: 3]);
  assign rx_sel = ir_q[DATA_W-4 -: 3];
  assign ry_sel = ir_q[DATA_W-7 -: 3];

`ifdef PROC_LOGIC_OPS_EN
  assign is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
`else
  assign is_alu = (op == OP_ADD) || (op == OP_SUB);
`endif

  always_comb begin
    alu_c = a_q + bus_c;
    case (op)
      OP_SUB:  alu_c = a_q - bus_c;
`ifdef PROC_LOGIC_OPS_EN
      OP_AND:  alu_c = a_q & bus_c;
      OP_OR:   alu_c = a_q | bus_c;
`endif
      default: alu_c = a_q + bus_c;
    endcase
  end

  always_comb begin
    state_d = state_q;
    bus_c   = '0;
    done_c  = 1'b0;
    ir_we   = 1'b0;
    rx_we   = 1'b0;
    a_we    = 1'b0;
    g_we    = 1'b0;
    case (state_q)
      T0: begin
        if (Run) begin
          ir_we   = 1'b1;
          state_d = T1;
        end
      end
      T1: begin
        state_d = T0;
        done_c  = 1'b1;
        if (is_alu) begin
          bus_c   = r_q[rx_sel];
          a_we    = 1'b1;
          done_c  = 1'b0;
          state_d = T2;
        end else begin
          case (op)
            OP_MV: begin
              bus_c = r_q[ry_sel];
              rx_we = 1'b1;
            end
            OP_MVI: begin
              bus_c = DIN;
              rx_we = 1'b1;
            end
            OP_MVNZ: begin
              bus_c = r_q[ry_sel];
              rx_we = (g_q != '0);
            end
            default: ;
          endcase
        end
      end
      T2: begin
        bus_c   = r_q[ry_sel];
        g_we    = 1'b1;
        state_d = T3;
      end
      T3: begin
        bus_c   = g_q;
        rx_we   = 1'b1;
        done_c  = 1'b1;
        state_d = T0;
      end
      default: state_d = T0;
    endcase
  end

  // Outputs are forced quiet while Reset is asserted, whatever step the FSM is in.
  assign Done = done_c & ~Reset;
  assign Bus  = Reset ? '0 : bus_c;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= T0;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      for (int unsigned i = 0; i < 8; i++) r_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (ir_we) ir_q <= DIN;
      if (a_we)  a_q  <= bus_c;
      if (g_we)  g_q  <= alu_c;
      if (rx_we) r_q[rx_sel] <= bus_c;
    end
  end

endmodule

// File: tb/tb_processor_gen2.sv
// Directed, table-driven bench for processor_gen2 at DATA_W=9; registers are observed through mv Rn,Rn.
module tb_processor_gen2;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Run;
  logic [8:0] DIN;
  logic       Done;
  logic [8:0] Bus;

  int applied    = 0;
  int miscompares = 0;

  processor_gen2 #(.DATA_W(9)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Run  (Run),
    .DIN  (DIN),
    .Done (Done),
    .Bus  (Bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [2:0] op;
    logic [2:0] x;
    logic [2:0] y;
    logic [8:0] imm;
    int         lat;
    logic [8:0] bus;
    logic [8:0] rv;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one instruction; returns cycles from IR capture to Done and the Bus value in the Done step.
  task automatic exec(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y,
                      input logic [8:0] imm, output int lat, output logic [8:0] dbus);
    @(negedge Clock);
    Run = 1'b1;
    DIN = {op, x, y};
    @(posedge Clock);
    #1;
    Run = 1'b0;
    DIN = imm;
    lat  = 0;
    dbus = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clock);
      if (Done) begin
        lat  = c;
        dbus = Bus;
        break;
      end
    end
  endtask

  task automatic read_reg(input logic [2:0] n, output logic [8:0] val);
    int lat;
    exec(3'b000, n, n, 9'h000, lat, val);
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y,
                              input logic [8:0] imm, input int lat, input logic [8:0] bus,
                              input logic [8:0] rv);
    vec_t v;
    v.op = op; v.x = x; v.y = y; v.imm = imm; v.lat = lat; v.bus = bus; v.rv = rv;
    return v;
  endfunction

  initial begin
    int         lat;
    logic [8:0] dbus, rd;

    tbl[0]  = mk(3'b001, 3'd0, 3'd0, 9'h005, 1, 9'h005, 9'h005); // mvi R0,5
    tbl[1]  = mk(3'b001, 3'd1, 3'd0, 9'h003, 1, 9'h003, 9'h003); // mvi R1,3
    tbl[2]  = mk(3'b010, 3'd0, 3'd1, 9'h000, 3, 9'h008, 9'h008); // add R0,R1
    tbl[3]  = mk(3'b000, 3'd3, 3'd0, 9'h000, 1, 9'h008, 9'h008); // mv R3,R0
    tbl[4]  = mk(3'b001, 3'd4, 3'd0, 9'h000, 1, 9'h000, 9'h000); // mvi R4,0
    tbl[5]  = mk(3'b001, 3'd5, 3'd0, 9'h001, 1, 9'h001, 9'h001); // mvi R5,1
    tbl[6]  = mk(3'b011, 3'd4, 3'd5, 9'h000, 3, 9'h1FF, 9'h1FF); // sub R4,R5 wraps
    tbl[7]  = mk(3'b001, 3'd1, 3'd0, 9'h007, 1, 9'h007, 9'h007); // mvi R1,7
    tbl[8]  = mk(3'b011, 3'd5, 3'd5, 9'h000, 3, 9'h000, 9'h000); // sub R5,R5 -> G=0
    tbl[9]  = mk(3'b110, 3'd2, 3'd1, 9'h000, 1, 9'h007, 9'h000); // mvnz, G=0: no write
    tbl[10] = mk(3'b010, 3'd3, 3'd5, 9'h000, 3, 9'h008, 9'h008); // add R3,R5 -> G=8
    tbl[11] = mk(3'b110, 3'd2, 3'd1, 9'h000, 1, 9'h007, 9'h007); // mvnz, G=8: write
    tbl[12] = mk(3'b010, 3'd2, 3'd2, 9'h000, 3, 9'h00E, 9'h00E); // add R2,R2 doubles
    tbl[13] = mk(3'b111, 3'd0, 3'd1, 9'h000, 1, 9'h000, 9'h008); // reserved no-op
    tbl[14] = mk(3'b001, 3'd0, 3'd0, 9'h0F0, 1, 9'h0F0, 9'h0F0); // mvi R0,0F0
    tbl[15] = mk(3'b001, 3'd1, 3'd0, 9'h03C, 1, 9'h03C, 9'h03C); // mvi R1,03C
`ifdef PROC_LOGIC_OPS_EN
    tbl[16] = mk(3'b100, 3'd0, 3'd1, 9'h000, 3, 9'h030, 9'h030); // and
`else
    tbl[16] = mk(3'b100, 3'd0, 3'd1, 9'h000, 1, 9'h000, 9'h0F0); // and as no-op
`endif
    tbl[17] = mk(3'b001, 3'd0, 3'd0, 9'h0F0, 1, 9'h0F0, 9'h0F0); // mvi R0,0F0
`ifdef PROC_LOGIC_OPS_EN
    tbl[18] = mk(3'b101, 3'd0, 3'd1, 9'h000, 3, 9'h0FC, 9'h0FC); // or
`else
    tbl[18] = mk(3'b101, 3'd0, 3'd1, 9'h000, 1, 9'h000, 9'h0F0); // or as no-op
`endif
    tbl[19] = mk(3'b011, 3'd6, 3'd0, 9'h000, 3, 9'h110, 9'h110); // sub R6,R0: 0-0F0

    Reset = 1'b1;
    Run   = 1'b0;
    DIN   = '0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("reset_done", {8'h00, Done}, 9'h000);
    chk("reset_bus", Bus, 9'h000);
    Reset = 1'b0;
    @(negedge Clock);
    chk("idle_done", {8'h00, Done}, 9'h000);
    chk("idle_bus", Bus, 9'h000);
    read_reg(3'd7, rd);
    chk("reset_r7", rd, 9'h000);

    for (int i = 0; i < 20; i++) begin
      exec(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].imm, lat, dbus);
      chk($sformatf("v%0d_latency", i), lat[8:0], tbl[i].lat[8:0]);
      chk($sformatf("v%0d_done_bus", i), dbus, tbl[i].bus);
      read_reg(tbl[i].x, rd);
      chk($sformatf("v%0d_R%0d", i, tbl[i].x), rd, tbl[i].rv);
    end

    // Abort an add R0,R1 in T2; G is nonzero beforehand so its clearing is observable.
    exec(3'b001, 3'd0, 3'd0, 9'h005, lat, dbus);
    exec(3'b001, 3'd1, 3'd0, 9'h003, lat, dbus);
    @(negedge Clock);
    Run = 1'b1;
    DIN = {3'b010, 3'd0, 3'd1};
    @(posedge Clock);
    #1;
    Run = 1'b0;
    DIN = '0;
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    @(negedge Clock);
    chk("abort_done_in_reset", {8'h00, Done}, 9'h000);
    chk("abort_bus_in_reset", Bus, 9'h000);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    @(negedge Clock);
    chk("abort_done_after", {8'h00, Done}, 9'h000);
    chk("abort_bus_after", Bus, 9'h000);
    read_reg(3'd0, rd);
    chk("abort_r0", rd, 9'h000);
    read_reg(3'd1, rd);
    chk("abort_r1", rd, 9'h000);
    exec(3'b001, 3'd2, 3'd0, 9'h009, lat, dbus);
    chk("post_reset_mvi_lat", lat[8:0], 9'd1);
    chk("post_reset_mvi_bus", dbus, 9'h009);
    read_reg(3'd2, rd);
    chk("post_reset_r2", rd, 9'h009);
    exec(3'b110, 3'd3, 3'd2, 9'h000, lat, dbus);
    read_reg(3'd3, rd);
    chk("post_reset_g_zero_mvnz", rd, 9'h000);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

endmodule

// File: doc/processor_gen2.md
# processor_gen2

Parametrised successor to the team's 9-bit multicycle bus processor. It holds eight general registers, an IR, an accumulator A and a result register G, all `DATA_W` bits wide, on one shared bus. An internal T-step state machine executes one instruction per Run request. Adds to the existing mv/mvi/add/sub set: bitwise and/or, and a conditional move `mvnz`.

## Interface
- `DATA_W`, default 9: datapath, register, IR, DIN and Bus width; legal range ≥ 9.
- `Clock` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: synchronous, active-high reset; sampled on the rising edge of `Clock`.
- `Run` in 1: start request; sampled only in T0.
- `DIN` in `DATA_W`: instruction word in T0; immediate operand in T1 of mvi.
- `Done` out 1: combinational; high during the final T-step of every instruction.
- `Bus` out `DATA_W`: current shared-bus value, for observation.

## Operation
- IR fields:
  - opcode = IR[W-1:W-3]
  - X = IR[W-4:W-6]
  - Y = IR[W-7:W-9]
  - IR[W-10:0] is ignored.
- Opcodes:
  - 000 mv: RX←RY
  - 001 mvi: RX←DIN
  - 010 add
  - 011 sub
  - 100 and
  - 101 or
  - 110 mvnz: RX←RY only if G≠0
  - 111 reserved: no-op
- Bus source select, one per step:
  - RX or RY, or G, or DIN
  - 0 when no source is selected (T0 and reserved-op steps)
- Arithmetic is modulo 2^DATA_W. Carry and borrow are discarded.
- sub computes G = A − Bus.
- A and G change only in the steps listed below. mvnz tests the G value left by the previous ALU op.
- FSM states and transitions:
  - T0 (idle/fetch): if Run=1, IR←DIN, go to T1; otherwise stay in T0. No other register changes.
  - T1:
    - mv: Bus=RY, RX←Bus, Done, go to T0.
    - mvi: Bus=DIN, RX←Bus, Done, go to T0.
    - ALU ops: Bus=RX, A←Bus, go to T2.
    - mvnz: Bus=RY, write RX only if G≠0, Done, go to T0.
    - reserved: Done, go to T0, no writes.
  - T2 (ALU ops only): Bus=RY, G←A op Bus, go to T3.
  - T3: Bus=G, RX←Bus, Done, go to T0.
- X=Y is legal. For example, add R2,R2 doubles R2.
- Run is ignored outside T0. Holding Run high starts the next instruction on the cycle after Done.

## Timing
- Reset=1 at an edge: state←T0, and IR, R0–R7, A, G←0, regardless of the current step. This aborts any instruction in flight with no partial writeback.
- Outputs during and after reset: Done=0, Bus=0.
- Latency counts cycles from the edge that captures IR, up to and including the Done cycle:
  - mv, mvi, mvnz, reserved: 1 cycle.
  - add, sub, and, or: 3 cycles.
- Register writes occur at the end of the Done cycle. The new value is visible on the next cycle.
- DIN must hold the immediate throughout the T1 of mvi.

## Configuration
- `PROC_LOGIC_OPS_EN` defined: opcodes 100 (and) and 101 (or) execute as described.
- `PROC_LOGIC_OPS_EN` undefined: opcodes 100 and 101 decode as reserved (1-cycle no-op with Done), and the ALU contains add/sub only.

## Test plan
All scenarios use DATA_W=9.
- mvi R0,5: DIN=001_000_000 with Run=1, then DIN=5 → Done high in T1; R0=5 next cycle; Bus=5 during T1.
- R0=5, R1=3; add R0,R1 (010_000_001) → Done in the third cycle after fetch; Bus=8 in T3; R0=8; G=8.
- R0=0, R1=1; sub R0,R1 → R0=0x1FF (wrap); G=0x1FF.
- G=0 then mvnz R2,R1 (R1=7) → R2 unchanged. Then add to make G=8; mvnz R2,R1 → R2=7.
- Reset mid-add, asserted in T2 → next cycle state is T0, all registers 0, Done=0, Bus=0; a following mvi executes normally.
- Opcode 111, and with the macro undefined opcodes 100 and 101 → Done after 1 cycle, no register or A/G change. With the macro defined, R0=0x0F0 and R1=0x03C: and → 0x030; or → 0x0FC.
